mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder_pkg.sv | 33 +++
 rtl/mem_responder_if.sv | 29 ++
 rtl/mem_responder_ram32_be.sv | 22 ++
 rtl/mem_responder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: state encoding, I/O map, STATUS bits.
package mem_responder_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // I/O register offsets relative to the base of the I/O window
  localparam int IO_TXDATA = 0;
  localparam int IO_STATUS = 1;
  localparam int IO_RXDATA = 2;
  localparam int IO_SNAP0  = 4;   // offsets 4..7, MSB first

  // STATUS bit positions
  localparam int STAT_TX_FULL  = 0;
  localparam int STAT_TX_EMPTY = 1;
  localparam int STAT_RX_HELD  = 2;
  localparam int STAT_OVERFLOW = 3;

  localparam int TX_DEPTH = 4;

  // Big-endian byte pick: lane 0 is the most significant byte of the word.
  function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] lane);
    case (lane)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU byte bus plus transmit/receive byte streams of the memory responder.
interface mem_responder_if #(parameter int addr_width = 9);
  import mem_responder_pkg::*;

  logic [addr_width-1:0] mem_raddr;
  logic [addr_width-1:0] mem_waddr;
  logic                  mem_write;
  logic [7:0]            mem_data_in;
  logic [7:0]            mem_data_out;
  logic                  mem_ready;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [7:0]            rx_data;
  logic                  rx_valid;

  // Environment side: CPU, transmit consumer and receive producer
  modport master (
    output mem_raddr, mem_waddr, mem_write, mem_data_in, tx_ready, rx_data, rx_valid,
    input  mem_data_out, mem_ready, tx_data, tx_valid
  );

  // Responder side
  modport slave (
    input  mem_raddr, mem_waddr, mem_write, mem_data_in, tx_ready, rx_data, rx_valid,
    output mem_data_out, mem_ready, tx_data, tx_valid
  );

endinterface

// File: rtl/mem_responder_ram32_be.sv
// 32-bit word RAM, per-byte write enables, registered read (old data on same-address write).
module ram32_be #(
  parameter int AW = 7
) (
  input  logic          clk,
  input  logic [3:0]    we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [1 << AW];

  // Byte-lane writes and synchronous read share one edge, so reads see pre-write contents
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++)
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: byte-addressed RAM with an I/O window (TX FIFO, RX holding
// register, cycle-counter snapshot) at the top of the address space. After reset
// the RAM is zeroed one word per cycle before accesses are accepted.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int addr_width = 9,
  parameter int io_bytes   = 8
) (
  input logic            clk,
  input logic            reset,
  mem_responder_if.slave bus
);

  localparam int WA        = addr_width - 2;
  localparam int WORDS     = 1 << WA;
  localparam int IO_BASE_I = (1 << addr_width) - io_bytes;
  localparam logic [addr_width-1:0] IO_BASE  = IO_BASE_I[addr_width-1:0];
  localparam logic [addr_width-1:0] OFF_TX   = addr_width'(IO_TXDATA);
  localparam logic [addr_width-1:0] OFF_STAT = addr_width'(IO_STATUS);
  localparam logic [addr_width-1:0] OFF_RX   = addr_width'(IO_RXDATA);
  localparam logic [addr_width-1:0] OFF_SN0  = addr_width'(IO_SNAP0);
  localparam logic [addr_width-1:0] OFF_SNE  = addr_width'(IO_SNAP0 + 4);
  localparam logic [WA-1:0]         LAST_WORD = WA'(WORDS - 1);

  // ---------------- clear FSM ----------------
  state_t        state, state_nx;
  logic [WA-1:0] clr_idx, clr_idx_nx;
  logic          clr_we;

  // State and clear index registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nx;
      clr_idx <= clr_idx_nx;
    end
  end

  // Walk the clear index across every word, then open for business
  always_comb begin
    state_nx   = state;
    clr_idx_nx = clr_idx;
    clr_we     = 1'b0;
    case (state)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (clr_idx == LAST_WORD) state_nx = ST_READY;
        else                      clr_idx_nx = clr_idx + 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- address decode ----------------
  logic                  ready, r_io, w_io;
  logic [addr_width-1:0] r_off, w_off;
  logic                  wr_en, ram_wr, io_wr;
  logic                  tx_push, ovf_clr, rx_rel, snap_wr;

  assign ready   = (state == ST_READY);
  assign r_io    = (bus.mem_raddr >= IO_BASE);
  assign w_io    = (bus.mem_waddr >= IO_BASE);
  assign r_off   = bus.mem_raddr - IO_BASE;
  assign w_off   = bus.mem_waddr - IO_BASE;
  assign wr_en   = bus.mem_write && ready;
  assign ram_wr  = wr_en && !w_io;
  assign io_wr   = wr_en && w_io;
  assign tx_push = io_wr && (w_off == OFF_TX);
  assign ovf_clr = io_wr && (w_off == OFF_STAT) && bus.mem_data_in[STAT_OVERFLOW];
  assign rx_rel  = io_wr && (w_off == OFF_RX);
  assign snap_wr = io_wr && (w_off == OFF_SN0);

  // ---------------- transmit FIFO ----------------
  logic [7:0] tx_mem [TX_DEPTH];
  logic [1:0] tx_rd, tx_wr;
  logic [2:0] tx_cnt;
  logic       tx_full, tx_empty, tx_pop, tx_acc, tx_drop, ovf;

  assign tx_full  = (tx_cnt == 3'(TX_DEPTH));
  assign tx_empty = (tx_cnt == 3'd0);
  assign tx_pop   = !tx_empty && bus.tx_ready;
  // A pop frees the head slot this same edge, so a push into a full FIFO still fits
  assign tx_acc   = tx_push && (!tx_full || tx_pop);
  assign tx_drop  = tx_push && tx_full && !tx_pop;

  // FIFO pointers, occupancy and sticky overflow (clear beats a simultaneous drop)
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_rd  <= '0;
      tx_wr  <= '0;
      tx_cnt <= '0;
      ovf    <= 1'b0;
    end else begin
      if (tx_acc) tx_wr <= tx_wr + 2'd1;
      if (tx_pop) tx_rd <= tx_rd + 2'd1;
      tx_cnt <= tx_cnt + 3'(tx_acc) - 3'(tx_pop);
      if (ovf_clr)      ovf <= 1'b0;
      else if (tx_drop) ovf <= 1'b1;
    end
  end

  // FIFO storage; contents are masked by occupancy so no reset is needed
  always_ff @(posedge clk) begin
    if (tx_acc) tx_mem[tx_wr] <= bus.mem_data_in;
  end

  assign bus.tx_valid = !tx_empty;
  assign bus.tx_data  = tx_empty ? 8'h00 : tx_mem[tx_rd];

  // ---------------- receive holding register ----------------
  logic       rx_held;
  logic [7:0] rx_byte;

  // Capture when empty or being released this cycle; release alone empties it
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_held <= 1'b0;
      rx_byte <= '0;
    end else if (bus.rx_valid && (!rx_held || rx_rel)) begin
      rx_held <= 1'b1;
      rx_byte <= bus.rx_data;
    end else if (rx_rel) begin
      rx_held <= 1'b0;
    end
  end

  // ---------------- cycle counter / snapshot ----------------
  logic [31:0] cyc_cnt, snap;

  // Free-running counter (wraps naturally) and snapshot copy on demand
  always_ff @(posedge clk) begin
    if (reset) begin
      cyc_cnt <= '0;
      snap    <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (snap_wr) snap <= cyc_cnt;
    end
  end

  // ---------------- I/O read mux ----------------
  logic [7:0] status, io_rdata;

  // Read value of the addressed I/O register from current (pre-write) state
  always_comb begin
    status                = '0;
    status[STAT_TX_FULL]  = tx_full;
    status[STAT_TX_EMPTY] = tx_empty;
    status[STAT_RX_HELD]  = rx_held;
    status[STAT_OVERFLOW] = ovf;
    io_rdata              = '0;
    if (r_off == OFF_STAT)                         io_rdata = status;
    else if (r_off == OFF_RX)                      io_rdata = rx_held ? rx_byte : 8'h00;
    else if ((r_off >= OFF_SN0) && (r_off < OFF_SNE)) io_rdata = be_byte(snap, r_off[1:0]);
  end

  // ---------------- RAM write pipeline and port mux ----------------
  logic          wq_vld;
  logic [WA-1:0] wq_word;
  logic [1:0]    wq_lane;
  logic [7:0]    wq_data;
  logic [3:0]    ram_we;
  logic [WA-1:0] ram_waddr;
  logic [31:0]   ram_wdata, ram_rdata;

  // Register the CPU write so it hits the array on the same edge the read does
  always_ff @(posedge clk) begin
    if (reset) begin
      wq_vld  <= 1'b0;
      wq_word <= '0;
      wq_lane <= '0;
      wq_data <= '0;
    end else begin
      wq_vld  <= ram_wr;
      wq_word <= bus.mem_waddr[addr_width-1:2];
      wq_lane <= bus.mem_waddr[1:0];
      wq_data <= bus.mem_data_in;
    end
  end

  // Clearing owns the write port; otherwise one big-endian byte lane of the pending write
  always_comb begin
    ram_we    = '0;
    ram_waddr = wq_word;
    ram_wdata = {4{wq_data}};
    if (clr_we) begin
      ram_we    = 4'hF;
      ram_waddr = clr_idx;
      ram_wdata = '0;
    end else if (wq_vld) begin
      ram_we = 4'b1000 >> wq_lane;
    end
  end

  // ---------------- read pipeline ----------------
  logic [WA-1:0] rq_word;
  logic [1:0]    rq_lane, r2_lane;
  logic          rq_io, r2_io, rq_ok, r2_ok;
  logic [7:0]    rq_io_data, r2_io_data, dout_q;

  ram32_be #(.AW(WA)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (rq_word),
    .rdata (ram_rdata)
  );

  // Stage 1 samples the address, stage 2 waits on the RAM, stage 3 drives the output
  always_ff @(posedge clk) begin
    if (reset) begin
      rq_word    <= '0;
      rq_lane    <= '0;
      rq_io      <= 1'b0;
      rq_io_data <= '0;
      rq_ok      <= 1'b0;
      r2_lane    <= '0;
      r2_io      <= 1'b0;
      r2_io_data <= '0;
      r2_ok      <= 1'b0;
      dout_q     <= '0;
    end else begin
      rq_word    <= bus.mem_raddr[addr_width-1:2];
      rq_lane    <= bus.mem_raddr[1:0];
      rq_io      <= r_io;
      rq_io_data <= io_rdata;
      rq_ok      <= ready;
      r2_lane    <= rq_lane;
      r2_io      <= rq_io;
      r2_io_data <= rq_io_data;
      r2_ok      <= rq_ok;
      if (!r2_ok)     dout_q <= '0;
      else if (r2_io) dout_q <= r2_io_data;
      else            dout_q <= be_byte(ram_rdata, r2_lane);
    end
  end

  assign bus.mem_data_out = dout_q;
  assign bus.mem_ready    = ready;

endmodule
